// File: rtl/sprite_fetch_if.sv
// Pixel stream, sprite-position request, ROM port and per-pixel output of sprite_fetch.
// The timing generator / ROM side is master; the fetch stage is slave.
interface sprite_fetch_if #(
  parameter int unsigned AddrW = 12,
  parameter int unsigned IdxW  = 5
);
  logic             frame_start;
  logic [9:0]       sprite_x;
  logic [9:0]       sprite_y;
  logic [9:0]       draw_x;
  logic [9:0]       draw_y;
  logic             de;
  logic [AddrW-1:0] read_address;
  logic [IdxW-1:0]  rom_data;
  logic [IdxW-1:0]  pix_index;
  logic             pix_opaque;
  logic             pix_valid;

  modport master (
    output frame_start, sprite_x, sprite_y, draw_x, draw_y, de, rom_data,
    input  read_address, pix_index, pix_opaque, pix_valid
  );

  modport slave (
    input  frame_start, sprite_x, sprite_y, draw_x, draw_y, de, rom_data,
    output read_address, pix_index, pix_opaque, pix_valid
  );
endinterface

// File: rtl/sprite_fetch.sv
// Sprite box test, ROM address generation and 3-edge re-alignment of the returned
// palette index with the pixel's in-box flag. Position is latched only at frame_start.
module sprite_fetch #(
  parameter int unsigned SpriteW   = 60,
  parameter int unsigned SpriteH   = 60,
  parameter int unsigned ScaleLog2 = 0,
  parameter int unsigned AddrW     = 12,
  parameter int unsigned IdxW      = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sprite_fetch_if.slave bus_io
);

  localparam int unsigned BoxW = SpriteW << ScaleLog2;
  localparam int unsigned BoxH = SpriteH << ScaleLog2;

  logic [9:0]       pos_x_q, pos_x_d;
  logic [9:0]       pos_y_q, pos_y_d;
  logic [AddrW-1:0] read_address_q, read_address_d;
  logic             v1_q, v1_d, b1_q, b1_d;
  logic             v2_q, v2_d, b2_q, b2_d;
  logic             pix_valid_q, pix_valid_d;
  logic [IdxW-1:0]  pix_index_q, pix_index_d;
  logic             pix_opaque_q, pix_opaque_d;

  logic [10:0]      dx, dy;
  logic [9:0]       tx, ty;
  logic [AddrW-1:0] tx_w, ty_w, tex_addr;
  logic             in_box;

  // 11-bit difference: bit 10 set means the pixel is left of / above the sprite.
  assign dx = {1'b0, bus_io.draw_x} - {1'b0, pos_x_q};
  assign dy = {1'b0, bus_io.draw_y} - {1'b0, pos_y_q};

  assign in_box = bus_io.de & ~dx[10] & ~dy[10]
                & (32'(dx[9:0]) < BoxW) & (32'(dy[9:0]) < BoxH);

  assign tx   = dx[9:0] >> ScaleLog2;
  assign ty   = dy[9:0] >> ScaleLog2;
  assign tx_w = AddrW'(tx);
  assign ty_w = AddrW'(ty);

  generate
    if (SpriteW == 60) begin : g_w60
      // ty*60 as ty*64 - ty*4 keeps the address path multiplier-free.
      assign tex_addr = (ty_w << 6) - (ty_w << 2) + tx_w;
    end else begin : g_wmul
      assign tex_addr = ty_w * AddrW'(SpriteW) + tx_w;
    end
  endgenerate

  always_comb begin
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    if (bus_io.frame_start) begin
      pos_x_d = bus_io.sprite_x;
      pos_y_d = bus_io.sprite_y;
    end
    read_address_d = in_box ? tex_addr : '0;
    v1_d           = bus_io.de;
    b1_d           = in_box;
    v2_d           = v1_q;
    b2_d           = b1_q;
    pix_valid_d    = v2_q;
    pix_index_d    = b2_q ? bus_io.rom_data : '0;
    pix_opaque_d   = b2_q & (|bus_io.rom_data);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_x_q        <= '0;
      pos_y_q        <= '0;
      read_address_q <= '0;
      v1_q           <= 1'b0;
      b1_q           <= 1'b0;
      v2_q           <= 1'b0;
      b2_q           <= 1'b0;
      pix_valid_q    <= 1'b0;
      pix_index_q    <= '0;
      pix_opaque_q   <= 1'b0;
    end else begin
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      read_address_q <= read_address_d;
      v1_q           <= v1_d;
      b1_q           <= b1_d;
      v2_q           <= v2_d;
      b2_q           <= b2_d;
      pix_valid_q    <= pix_valid_d;
      pix_index_q    <= pix_index_d;
      pix_opaque_q   <= pix_opaque_d;
    end
  end

  assign bus_io.read_address = read_address_q;
  assign bus_io.pix_valid    = pix_valid_q;
  assign bus_io.pix_index    = pix_index_q;
  assign bus_io.pix_opaque   = pix_opaque_q;

endmodule

// File: doc/sprite_fetch.md
# sprite_fetch

Pixel-pipeline stage that sits between the VGA timing generator and a 60x60 on-chip sprite ROM (5-bit palette index, 12-bit address, one-cycle registered read). For every incoming screen coordinate it decides whether the pixel lies inside the sprite box, generates the ROM read address, and re-aligns the returned palette index with a delayed in-box flag. The output is a per-pixel index plus an opaque flag for the colour mapper. Sprite position is double-buffered and only updates at a frame-start pulse, so a sprite never tears mid-frame.

## Interface
- SPR_W, 60, sprite width in source texels
- SPR_H, 60, sprite height in source texels
- SCALE_LOG2, 0, on-screen magnification = 2^SCALE_LOG2 (legal 0..2)
- ADDR_W, 12, ROM address width
- IDX_W, 5, palette index width

- Clk  in  1  pixel clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- frame_start  in  1  one-cycle pulse at start of vertical blank; loads pending position
- SpriteX  in  10  requested sprite left edge, screen pixels, unsigned
- SpriteY  in  10  requested sprite top edge, screen pixels, unsigned
- DrawX  in  10  current screen column
- DrawY  in  10  current screen row
- de  in  1  display enable for DrawX/DrawY
- read_address  out  ADDR_W  ROM address, registered
- rom_data  in  IDX_W  ROM data_Out, valid one cycle after read_address
- pix_index  out  IDX_W  palette index for the pixel, registered
- pix_opaque  out  1  1 = sprite covers pixel (in box, index != 0)
- pix_valid  out  1  delayed de, aligned with pix_index

## Operation
- Position registers pos_x/pos_y: load SpriteX/SpriteY on the edge where frame_start=1; otherwise hold. Reset value 0. DrawX/DrawY compare against pos_x/pos_y only, never directly against SpriteX/SpriteY.
- Stage 1 (edge k):
  - dx = DrawX - pos_x, dy = DrawY - pos_y, each computed 11-bit signed.
  - in_box = de & dx>=0 & dy>=0 & dx < SPR_W<<SCALE_LOG2 & dy < SPR_H<<SCALE_LOG2.
  - tx = dx>>SCALE_LOG2, ty = dy>>SCALE_LOG2.
  - read_address <= in_box ? ty*SPR_W + tx : 0. For SPR_W=60, use (ty<<6)-(ty<<2)+tx; no DSP multiplier needed. Maximum value is 3599; it fits in 12 bits with no wrap.
  - v1 <= de, b1 <= in_box.
- Stage 2 (edge k+1): ROM registers data. v2 <= v1, b2 <= b1.
- Stage 3 (edge k+2):
  - pix_valid <= v2.
  - pix_index <= b2 ? rom_data : 0.
  - pix_opaque <= b2 & (rom_data != 0).
- Index 0 is transparent by definition.
- Sprite partly past the right/bottom screen edge: the out-of-screen texels are simply never addressed. No special handling.
- frame_start while de=1 (illegal timing): the load still occurs. The pipeline is not flushed; at most two pixels already in flight use the old position.
- Reset asserted mid-frame: all outputs go 0 immediately (async). The pipeline restarts on the first edge after deassertion; the first valid output is 2 edges later.

## Timing
- Inputs sampled at edge k → read_address valid after edge k → rom_data valid after edge k+1 → pix_* valid after edge k+2.
- Fixed latency of 3 edges, inclusive of ROM. Throughput is one pixel per clock with no stalls.
- The VGA controller must delay its sync/blank signals by 3 clocks to match.
- Reset values: read_address=0, pix_index=0, pix_opaque=0, pix_valid=0, pos_x=pos_y=0, v1/v2/b1/b2=0.
- Position loaded at edge j affects pixels sampled at edge j+1 onward.

## Test plan
- Reset then frame_start with SpriteX=100, SpriteY=50; drive DrawX=100, DrawY=50, de=1 → read_address=0 after first edge; pix_valid=1, pix_opaque tracks ROM[0] 2 edges later.
- DrawX=159, DrawY=109 (last texel) → read_address=3599. DrawX=160 → out of box: read_address=0, pix_index=0, pix_opaque=0 after latency.
- SCALE_LOG2=1, pos (0,0), DrawX=3, DrawY=5 → tx=1, ty=2, read_address=121. DrawX=119 still in box; DrawX=120 out of box.
- Change SpriteX to 300 without frame_start; sweep a row → hits still at the old position. Pulse frame_start → the next row hits at 300.
- Model ROM with entry 7 = 0 and entry 8 = 13; address those texels → pix_opaque=0/pix_index=0, then pix_opaque=1/pix_index=13, on consecutive cycles.
- Assert Reset between streamed in-box pixels → all outputs 0 asynchronously; after release, pix_valid rises exactly 3 edges after the first de=1 sample.
